// File: rtl/mor1kx_rf_wrport_ctrl_pkg.sv
// rtl/mor1kx_rf_wrport_ctrl_pkg.sv - shared state encoding and SPR group constant for the RF write port
package mor1kx_rf_wrport_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACK  = 2'd2
  } rf_state_t;

  // SPR group holding the debug/shadow view of the GPR file
  localparam logic [6:0] SPR_GROUP_GPR = 7'h2;

endpackage

// File: rtl/mor1kx_rf_clear_seq.sv
// rtl/mor1kx_rf_clear_seq.sv - post-reset clear address counter with writeback hold
module mor1kx_rf_clear_seq #(
  parameter int ADDR_W = 6,
  parameter int WORDS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic              hold,
  output logic [ADDR_W-1:0] clr_adr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);

  logic step;

  // A writeback collision holds the counter so the word is rewritten next cycle
  assign step = active & ~hold;
  assign done = step & (clr_adr == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      clr_adr <= '0;
    else if (step)
      clr_adr <= done ? '0 : clr_adr + ADDR_W'(1);
  end

endmodule

// File: rtl/mor1kx_rf_wrport_ctrl.sv
// rtl/mor1kx_rf_wrport_ctrl.sv - RF write-port arbiter, init clear and SPR GPR access sequencer
module mor1kx_rf_wrport_ctrl
  import mor1kx_rf_wrport_ctrl_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH    = 32,
  parameter int OPTION_RF_ADDR_WIDTH    = 5,
  parameter int RF_ADDR_WIDTH           = 6,
  parameter int OPTION_RF_WORDS         = 64,
  parameter int OPTION_RF_CLEAR_ON_INIT = 1,
  parameter int STARVE_LIMIT            = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
  input  logic                            padv_ctrl_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic                            spr_rden_o,
  output logic [RF_ADDR_WIDTH-1:0]        spr_rdad_o,
  output logic                            rf_wren_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o,
  output logic                            rf_init_busy_o,
  output logic                            spr_stall_o
);

  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
  localparam rf_state_t RESET_STATE = (OPTION_RF_CLEAR_ON_INIT != 0) ? ST_INIT : ST_IDLE;

  rf_state_t                 state, state_next;
  logic                      sel;
  logic                      spr_wr_req, spr_wr_grant, spr_rd_req;
  logic                      clr_active, clr_done;
  logic [RF_ADDR_WIDTH-1:0]  clr_adr;
  logic [WAIT_W-1:0]         wait_cnt;
  logic                      unused_addr_bits;

  assign unused_addr_bits = &{1'b0, spr_bus_addr_i};

  assign sel          = (spr_bus_addr_i[15:9] == SPR_GROUP_GPR) & spr_bus_stb_i;
  assign spr_wr_req   = (state == ST_IDLE) & sel & spr_bus_we_i;
  assign spr_wr_grant = spr_wr_req & ~wb_rf_wb_i;
  assign spr_rd_req   = (state == ST_IDLE) & sel & ~spr_bus_we_i & ~padv_ctrl_i;
  assign clr_active   = (state == ST_INIT);

  mor1kx_rf_clear_seq #(
    .ADDR_W (RF_ADDR_WIDTH),
    .WORDS  (OPTION_RF_WORDS)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .active  (clr_active),
    .hold    (wb_rf_wb_i),
    .clr_adr (clr_adr),
    .done    (clr_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= RESET_STATE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (clr_done) state_next = ST_IDLE;
      ST_IDLE: if (spr_wr_grant | spr_rd_req) state_next = ST_ACK;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = RESET_STATE;
    endcase
  end

  // Write port is combinational; gating with rst keeps it quiet while reset is held
  always_comb begin
    rf_wren_o      = 1'b0;
    rf_wradr_o     = RF_ADDR_WIDTH'(wb_rfd_adr_i);
    rf_wrdat_o     = result_i;
    spr_rden_o     = rst & spr_rd_req;
    spr_rdad_o     = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
    spr_gpr_ack_o  = (state == ST_ACK);
    rf_init_busy_o = (state == ST_INIT);
    if (wb_rf_wb_i) begin
      rf_wren_o = rst;
    end else if (spr_wr_req) begin
      rf_wren_o  = rst;
      rf_wradr_o = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];
      rf_wrdat_o = spr_bus_dat_i;
    end else if (clr_active) begin
      rf_wren_o  = rst;
      rf_wradr_o = clr_adr;
      rf_wrdat_o = '0;
    end
  end

  // Counts only while an idle SPR write is blocked by writeback; any other cycle clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wait_cnt <= '0;
    else if (spr_wr_req & wb_rf_wb_i) begin
      if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end else
      wait_cnt <= '0;
  end

  assign spr_stall_o = (wait_cnt == WAIT_MAX);

endmodule

// File: tb/tb_mor1kx_rf_wrport_ctrl.sv
// tb/tb_mor1kx_rf_wrport_ctrl.sv - directed self-checking bench for the RF write-port controller
module tb_mor1kx_rf_wrport_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_rf_wb_i = 1'b0;
  logic [4:0]  wb_rfd_adr_i = '0;
  logic [31:0] result_i = '0;
  logic        padv_ctrl_i = 1'b0;
  logic [15:0] spr_bus_addr_i = '0;
  logic        spr_bus_stb_i = 1'b0;
  logic        spr_bus_we_i = 1'b0;
  logic [31:0] spr_bus_dat_i = '0;
  logic        spr_gpr_ack_o;
  logic        spr_rden_o;
  logic [5:0]  spr_rdad_o;
  logic        rf_wren_o;
  logic [5:0]  rf_wradr_o;
  logic [31:0] rf_wrdat_o;
  logic        rf_init_busy_o;
  logic        spr_stall_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];
  logic [31:0] ram_q;

  always #5 clk = ~clk;

  mor1kx_rf_wrport_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .wb_rf_wb_i     (wb_rf_wb_i),
    .wb_rfd_adr_i   (wb_rfd_adr_i),
    .result_i       (result_i),
    .padv_ctrl_i    (padv_ctrl_i),
    .spr_bus_addr_i (spr_bus_addr_i),
    .spr_bus_stb_i  (spr_bus_stb_i),
    .spr_bus_we_i   (spr_bus_we_i),
    .spr_bus_dat_i  (spr_bus_dat_i),
    .spr_gpr_ack_o  (spr_gpr_ack_o),
    .spr_rden_o     (spr_rden_o),
    .spr_rdad_o     (spr_rdad_o),
    .rf_wren_o      (rf_wren_o),
    .rf_wradr_o     (rf_wradr_o),
    .rf_wrdat_o     (rf_wrdat_o),
    .rf_init_busy_o (rf_init_busy_o),
    .spr_stall_o    (spr_stall_o)
  );

  // Register-file RAM with one-cycle SPR-side read latency
  always @(posedge clk) begin
    if (rf_wren_o) mem[rf_wradr_o] <= rf_wrdat_o;
    if (spr_rden_o) ram_q <= mem[spr_rdad_o];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    wb_rf_wb_i = 1'b0;
    spr_bus_stb_i = 1'b0;
    padv_ctrl_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wb_rf_wb_i = 1'b1;
    wb_rfd_adr_i = 5'd2;
    spr_bus_addr_i = 16'h0403;
    spr_bus_stb_i = 1'b1;
    spr_bus_we_i = 1'b0;
    tick();
    #2;
    checks++; if (rf_wren_o !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", rf_wren_o); end
    checks++; if (spr_rden_o !== 1'b0) begin errors++; $display("FAIL reset_rden got %b want 0", spr_rden_o); end
    checks++; if (spr_gpr_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", spr_gpr_ack_o); end
    checks++; if (spr_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", spr_stall_o); end
    checks++; if (rf_init_busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", rf_init_busy_o); end
    wb_rf_wb_i = 1'b0;
    spr_bus_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_sweep;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      #2;
      if (rf_wren_o !== 1'b1 || rf_wradr_o !== 6'(i) || rf_wrdat_o !== 32'd0 || rf_init_busy_o !== 1'b1) bad++;
      tick();
    end
    #2;
    checks++; if (bad !== 0) begin errors++; $display("FAIL sweep_writes bad_cycles got %0d want 0", bad); end
    checks++; if (rf_init_busy_o !== 1'b0) begin errors++; $display("FAIL sweep_busy_end got %b want 0", rf_init_busy_o); end
    checks++; if (rf_wren_o !== 1'b0) begin errors++; $display("FAIL sweep_idle_wren got %b want 0", rf_wren_o); end
    checks++; if (mem[63] !== 32'd0 || mem[0] !== 32'd0) begin errors++; $display("FAIL sweep_mem got %h/%h want 0", mem[0], mem[63]); end
  endtask

  task automatic test_sweep_collision;
    int bad = 0;
    int exp_adr = 0;
    do_reset();
    for (int c = 0; c < 65; c++) begin
      if (c == 10) begin
        wb_rf_wb_i = 1'b1;
        wb_rfd_adr_i = 5'd3;
        result_i = 32'hDEADBEEF;
        #2;
        checks++; if (rf_wren_o !== 1'b1 || rf_wradr_o !== 6'd3 || rf_wrdat_o !== 32'hDEADBEEF) begin
          errors++; $display("FAIL collide_wb got %b/%0d/%h want 1/3/deadbeef", rf_wren_o, rf_wradr_o, rf_wrdat_o); end
        tick();
        wb_rf_wb_i = 1'b0;
      end else begin
        #2;
        if (rf_wren_o !== 1'b1 || rf_wradr_o !== 6'(exp_adr) || rf_wrdat_o !== 32'd0 || rf_init_busy_o !== 1'b1) bad++;
        exp_adr++;
        tick();
      end
    end
    #2;
    checks++; if (bad !== 0) begin errors++; $display("FAIL collide_sweep bad_cycles got %0d want 0", bad); end
    checks++; if (rf_init_busy_o !== 1'b0) begin errors++; $display("FAIL collide_busy_end got %b want 0", rf_init_busy_o); end
  endtask

  task automatic test_spr_write;
    spr_bus_addr_i = 16'h0405;
    spr_bus_dat_i = 32'h12345678;
    spr_bus_we_i = 1'b1;
    spr_bus_stb_i = 1'b1;
    #2;
    checks++; if (rf_wren_o !== 1'b1 || rf_wradr_o !== 6'd5 || rf_wrdat_o !== 32'h12345678) begin
      errors++; $display("FAIL sprw_issue got %b/%0d/%h want 1/5/12345678", rf_wren_o, rf_wradr_o, rf_wrdat_o); end
    checks++; if (spr_gpr_ack_o !== 1'b0) begin errors++; $display("FAIL sprw_early_ack got %b want 0", spr_gpr_ack_o); end
    tick();
    #2;
    checks++; if (spr_gpr_ack_o !== 1'b1) begin errors++; $display("FAIL sprw_ack got %b want 1", spr_gpr_ack_o); end
    checks++; if (rf_wren_o !== 1'b0) begin errors++; $display("FAIL sprw_ack_wren got %b want 0", rf_wren_o); end
    spr_bus_stb_i = 1'b0;
    tick();
    #2;
    checks++; if (spr_gpr_ack_o !== 1'b0) begin errors++; $display("FAIL sprw_ack_pulse got %b want 0", spr_gpr_ack_o); end
    checks++; if (mem[5] !== 32'h12345678) begin errors++; $display("FAIL sprw_mem got %h want 12345678", mem[5]); end
    tick();
  endtask

  task automatic test_starve;
    wb_rf_wb_i = 1'b1;
    wb_rfd_adr_i = 5'd1;
    result_i = 32'h000000AA;
    spr_bus_addr_i = 16'h0409;
    spr_bus_dat_i = 32'h00000055;
    spr_bus_we_i = 1'b1;
    spr_bus_stb_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #2;
      checks++; if (rf_wradr_o !== 6'd1 || rf_wrdat_o !== 32'hAA) begin
        errors++; $display("FAIL starve_wb_c%0d got %0d/%h want 1/aa", k, rf_wradr_o, rf_wrdat_o); end
      checks++; if (spr_stall_o !== (k >= 4)) begin
        errors++; $display("FAIL starve_stall_c%0d got %b want %b", k, spr_stall_o, (k >= 4)); end
      tick();
    end
    wb_rf_wb_i = 1'b0;
    #2;
    checks++; if (rf_wren_o !== 1'b1 || rf_wradr_o !== 6'd9 || rf_wrdat_o !== 32'h55) begin
      errors++; $display("FAIL starve_grant got %b/%0d/%h want 1/9/55", rf_wren_o, rf_wradr_o, rf_wrdat_o); end
    checks++; if (spr_gpr_ack_o !== 1'b0) begin errors++; $display("FAIL starve_early_ack got %b want 0", spr_gpr_ack_o); end
    tick();
    #2;
    checks++; if (spr_gpr_ack_o !== 1'b1) begin errors++; $display("FAIL starve_ack got %b want 1", spr_gpr_ack_o); end
    checks++; if (spr_stall_o !== 1'b0) begin errors++; $display("FAIL starve_stall_clear got %b want 0", spr_stall_o); end
    spr_bus_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_spr_read;
    wb_rf_wb_i = 1'b1;
    wb_rfd_adr_i = 5'd7;
    result_i = 32'hCAFEF00D;
    tick();
    wb_rf_wb_i = 1'b0;
    spr_bus_addr_i = 16'h0407;
    spr_bus_we_i = 1'b0;
    spr_bus_stb_i = 1'b1;
    padv_ctrl_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      checks++; if (spr_rden_o !== 1'b0 || spr_gpr_ack_o !== 1'b0) begin
        errors++; $display("FAIL rd_blocked_c%0d got rden=%b ack=%b want 0/0", k, spr_rden_o, spr_gpr_ack_o); end
      tick();
    end
    padv_ctrl_i = 1'b0;
    #2;
    checks++; if (spr_rden_o !== 1'b1 || spr_rdad_o !== 6'd7) begin
      errors++; $display("FAIL rd_issue got %b/%0d want 1/7", spr_rden_o, spr_rdad_o); end
    tick();
    #2;
    checks++; if (spr_gpr_ack_o !== 1'b1 || spr_rden_o !== 1'b0) begin
      errors++; $display("FAIL rd_ack got ack=%b rden=%b want 1/0", spr_gpr_ack_o, spr_rden_o); end
    checks++; if (ram_q !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data got %h want cafef00d", ram_q); end
    spr_bus_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      spr_bus_addr_i = 16'h0401;
      spr_bus_we_i = 1'b1;
      spr_bus_stb_i = (c == 20);
      tick();
      #2;
      if (c == 20) begin
        checks++; if (spr_gpr_ack_o !== 1'b0) begin errors++; $display("FAIL init_sel_ack got %b want 0", spr_gpr_ack_o); end
      end
    end
    spr_bus_stb_i = 1'b0;
    checks++; if (rf_wradr_o !== 6'd30 || rf_wren_o !== 1'b1) begin
      errors++; $display("FAIL mid_sweep_adr got %b/%0d want 1/30", rf_wren_o, rf_wradr_o); end
    rst = 1'b0;
    #1;
    checks++; if (rf_wren_o !== 1'b0 || rf_init_busy_o !== 1'b1 || spr_gpr_ack_o !== 1'b0 || spr_stall_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outs got wren=%b busy=%b ack=%b stall=%b want 0/1/0/0",
                         rf_wren_o, rf_init_busy_o, spr_gpr_ack_o, spr_stall_o); end
    tick();
    rst = 1'b1;
    #2;
    checks++; if (rf_wren_o !== 1'b1 || rf_wradr_o !== 6'd0) begin
      errors++; $display("FAIL restart_adr0 got %b/%0d want 1/0", rf_wren_o, rf_wradr_o); end
    tick();
    #2;
    checks++; if (rf_wradr_o !== 6'd1) begin errors++; $display("FAIL restart_adr1 got %0d want 1", rf_wradr_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep();
    test_spr_write();
    test_starve();
    test_spr_read();
    test_sweep_collision();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mor1kx_rf_wrport_ctrl.md
# mor1kx_rf_wrport_ctrl

Write-port controller and SPR-access sequencer for the cappuccino GPR file. Sits between writeback, the SPR bus (debug unit / shadow-GPR access at SPR group 0x2, i.e. `spr_bus_addr_i[15:9]==7'h2`) and the register-file RAMs. It does three things:
- Clears every RF word after reset.
- Arbitrates the single RF write port, writeback always first.
- Sequences SPR GPR reads and writes with a fixed-latency ack, raising a pipeline stall request if an SPR write is starved.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, data width
- OPTION_RF_ADDR_WIDTH, 5, architectural GPR address width
- RF_ADDR_WIDTH, 6, physical RF address width (≥ OPTION_RF_ADDR_WIDTH; includes shadow sets)
- OPTION_RF_WORDS, 64, words cleared by the init sweep (≤ 2^RF_ADDR_WIDTH)
- OPTION_RF_CLEAR_ON_INIT, 1, 1 = run the clear sweep after reset
- STARVE_LIMIT, 4, cycles an SPR write may be blocked before a stall is requested

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- wb_rf_wb_i  in  1  writeback write enable
- wb_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  writeback destination
- result_i  in  OPTION_OPERAND_WIDTH  writeback data
- padv_ctrl_i  in  1  ctrl-stage advance; SPR reads are blocked while high
- spr_bus_addr_i  in  16  SPR address
- spr_bus_stb_i  in  1  SPR strobe
- spr_bus_we_i  in  1  SPR write
- spr_bus_dat_i  in  OPTION_OPERAND_WIDTH  SPR write data
- spr_gpr_ack_o  out  1  SPR GPR access ack, one-cycle pulse
- spr_rden_o  out  1  read enable to the SPR-side RF RAM
- spr_rdad_o  out  RF_ADDR_WIDTH  read address, equal to `spr_bus_addr_i[RF_ADDR_WIDTH-1:0]`
- rf_wren_o  out  1  RF write enable
- rf_wradr_o  out  RF_ADDR_WIDTH  RF write address
- rf_wrdat_o  out  OPTION_OPERAND_WIDTH  RF write data
- rf_init_busy_o  out  1  clear sweep in progress; pipeline must hold
- spr_stall_o  out  1  request to freeze writeback so a starved SPR write can proceed

## Operation
- States are INIT, IDLE and ACK. On reset the FSM enters INIT when OPTION_RF_CLEAR_ON_INIT=1, otherwise IDLE.
- The SPR GPR hit is `sel = (spr_bus_addr_i[15:9]==7'h2) & spr_bus_stb_i`.
- Write-port priority is writeback, then SPR write, then init sweep. The write port is combinational from inputs and state.
- Writeback path:
  - `rf_wradr_o` = `wb_rfd_adr_i` zero-extended to RF_ADDR_WIDTH.
  - `rf_wrdat_o` = `result_i`.
  - Writeback is granted in every state.
- INIT:
  - A counter `clr_adr` starts at 0.
  - Each cycle without writeback: write zero to `clr_adr`, then increment it.
  - Each cycle with writeback: `clr_adr` holds, so no word is skipped.
  - After writing word OPTION_RF_WORDS-1, go to IDLE.
  - `rf_init_busy_o` is high in INIT.
  - `sel` is ignored in INIT; no ack is given.
- IDLE, SPR write (`sel & spr_bus_we_i`):
  - If `!wb_rf_wb_i`: drive `rf_wren_o`=1 with `rf_wradr_o` = `spr_bus_addr_i[RF_ADDR_WIDTH-1:0]` and `rf_wrdat_o` = `spr_bus_dat_i`, then go to ACK.
  - Otherwise the write is blocked and `wait_cnt` increments, saturating at STARVE_LIMIT.
- IDLE, SPR read (`sel & !spr_bus_we_i & !padv_ctrl_i`): drive `spr_rden_o`=1 and go to ACK. Read data comes from the RAM one cycle later.
- ACK: `spr_gpr_ack_o`=1 for exactly one cycle, then return to IDLE. A second request is not examined until IDLE.
- Starvation: `spr_stall_o = (wait_cnt==STARVE_LIMIT)`. It stays high until the write is granted. `wait_cnt` clears on grant or when `sel` drops.

## Timing
- While reset is asserted:
  - `rf_wren_o`=0, `spr_rden_o`=0, `spr_gpr_ack_o`=0, `spr_stall_o`=0.
  - `rf_init_busy_o`=OPTION_RF_CLEAR_ON_INIT.
  - `clr_adr`=0, `wait_cnt`=0.
- Clear sweep takes OPTION_RF_WORDS cycles plus one cycle per writeback collision. `rf_init_busy_o` falls in the cycle after the last clear write.
- SPR write: write in grant cycle N, ack in N+1.
- SPR read: `spr_rden_o` in cycle N, ack in N+1 with RAM data valid at the same time.
- If `stb` drops in cycle N+1, the ack still pulses; the bus ignores it.
- Writeback and SPR write in the same cycle: writeback writes; the SPR write retries next cycle. No SPR data is lost because `stb` and data are held until ack.
- If reset is asserted mid-sweep or mid-ACK, the FSM returns immediately to the reset state and the sweep restarts from 0.

## Structure
- The FSM state encoding and the SPR group constant (7'h2) go in the shared mor1kx defines package.
- One sub-module is natural: `mor1kx_rf_clear_seq`, holding the clear counter and its done/hold logic.
- Arbitration, the ACK FSM and the starvation counter live in the top module.

## Test plan
- Reset with CLEAR_ON_INIT=1, WORDS=64, no writeback: exactly 64 zero writes to addresses 0..63; `rf_init_busy_o` falls at cycle 64.
- During the sweep, writeback to r3 with 0xDEADBEEF at `clr_adr`=10: the writeback goes out that cycle, `clr_adr` holds at 10, and the sweep still finishes all 64 words (65 cycles total).
- SPR write to 0x0405 with 0x12345678 while idle: write to address 5 at cycle N; `spr_gpr_ack_o` pulses only at N+1.
- SPR write while `wb_rf_wb_i` is held high for 6 cycles with STARVE_LIMIT=4: `spr_stall_o` rises after 4 blocked cycles; when writeback drops, the SPR write is issued, stall clears, and ack follows one cycle later.
- SPR read of 0x0407 with `padv_ctrl_i`=1 for 2 cycles: no `spr_rden_o` during those cycles; after `padv_ctrl_i` drops, `spr_rden_o` with address 7, then ack next cycle with RAM data.
- Reset asserted at `clr_adr`=30: all outputs go to reset values immediately; after release the sweep restarts at address 0.
